// File: rtl/fir_param.sv
// Parametrised direct-form FIR with serial coefficient load, sticky protocol error and
// selectable signed/unsigned arithmetic. Define FIR_SATURATE_EN to clamp the output instead of wrapping.
module fir_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned NTAPS  = 5,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              coef_enable,
  input  logic              sample_enable,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_enable,
  output logic              coef_ready,
  output logic              error
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NTAPS);
  localparam int unsigned IDX_W  = $clog2(NTAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COEF_W-1:0] coef     [NTAPS];
  logic [DATA_W-1:0] hist     [NTAPS];
  logic [DATA_W-1:0] hist_nxt [NTAPS];
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  coef_waddr;
  logic              coef_we;
  logic              sample_we;
  logic              load_done;
  logic              reload;
  logic              conflict;
  logic [ACC_W-1:0]  acc;
  logic [OUT_W-1:0]  y_c;

  assign conflict = coef_enable & sample_enable;

  function automatic logic [ACC_W-1:0] ext_x(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return ACC_W'($signed(v));
    else             return ACC_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] ext_c(input logic [COEF_W-1:0] v);
    if (SIGNED != 0) return ACC_W'($signed(v));
    else             return ACC_W'(v);
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic; ERR is only left through reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (sample_enable)                           state_nxt = S_ERR;
        else if (coef_enable && (idx == LAST_IDX))   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (conflict)         state_nxt = S_ERR;
        else if (coef_enable) state_nxt = S_LOAD;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Per-state action decode
  always_comb begin
    coef_we    = 1'b0;
    coef_waddr = idx;
    sample_we  = 1'b0;
    load_done  = 1'b0;
    reload     = 1'b0;
    idx_nxt    = idx;
    case (state)
      S_LOAD: begin
        if (coef_enable && !sample_enable) begin
          coef_we = 1'b1;
          if (idx == LAST_IDX) begin
            load_done = 1'b1;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (coef_enable && !sample_enable) begin
          // Reload writes c[0] on the entry edge, so loading continues at index 1
          coef_we    = 1'b1;
          coef_waddr = '0;
          reload     = 1'b1;
          idx_nxt    = IDX_W'(1);
        end else if (sample_enable && !coef_enable) begin
          sample_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // History including the incoming sample
  always_comb begin
    hist_nxt[0] = data_in;
    for (int k = 1; k < int'(NTAPS); k++) hist_nxt[k] = hist[k-1];
  end

  // Full-precision MAC; operands extended to ACC_W so the low ACC_W product bits are exact
  always_comb begin
    acc = '0;
    for (int k = 0; k < int'(NTAPS); k++) acc = acc + ext_x(hist_nxt[k]) * ext_c(coef[k]);
  end

  generate
    if (OUT_W >= ACC_W) begin : g_wide
      always_comb begin
        if (SIGNED != 0) y_c = OUT_W'($signed(acc));
        else             y_c = OUT_W'(acc);
      end
    end else begin : g_narrow
`ifdef FIR_SATURATE_EN
      localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W - 1);
      logic [ACC_W-OUT_W:0] hi;
      assign hi = acc[ACC_W-1:OUT_W-1];
      // Clamp when the discarded bits do not agree with the kept range
      always_comb begin
        y_c = acc[OUT_W-1:0];
        if (SIGNED != 0) begin
          if (!(&hi) && (|hi)) y_c = acc[ACC_W-1] ? SMIN : ~SMIN;
        end else if (|acc[ACC_W-1:OUT_W]) begin
          y_c = '1;
        end
      end
`else
      logic unused_acc_hi;
      assign unused_acc_hi = ^acc[ACC_W-1:OUT_W];
      always_comb y_c = acc[OUT_W-1:0];
`endif
    end
  endgenerate

  // Coefficient and history storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(NTAPS); k++) begin
        coef[k] <= '0;
        hist[k] <= '0;
      end
      idx <= '0;
    end else begin
      idx <= idx_nxt;
      if (coef_we) coef[coef_waddr] <= data_in[COEF_W-1:0];
      if (sample_we) begin
        for (int k = 0; k < int'(NTAPS); k++) hist[k] <= hist_nxt[k];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      out_enable <= 1'b0;
      coef_ready <= 1'b0;
      error      <= 1'b0;
    end else begin
      out_enable <= sample_we;
      if (sample_we) data_out <= y_c;
      if (load_done)   coef_ready <= 1'b1;
      else if (reload) coef_ready <= 1'b0;
      error <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// Directed table-driven bench for fir_param: unsigned default instance plus a SIGNED=1 instance.
module tb_fir_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic [15:0] dout_u, dout_s;
  logic        oe_u, oe_s, rdy_u, rdy_s, err_u, err_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_param dut (
    .clk(clk), .reset(reset), .data_in(data_in), .coef_enable(coef_enable),
    .sample_enable(sample_enable), .data_out(dout_u), .out_enable(oe_u),
    .coef_ready(rdy_u), .error(err_u)
  );

  fir_param #(.SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .data_in(data_in), .coef_enable(coef_enable),
    .sample_enable(sample_enable), .data_out(dout_s), .out_enable(oe_s),
    .coef_ready(rdy_s), .error(err_s)
  );

  typedef struct {
    bit          rst;
    bit          ce;
    bit          se;
    bit          sgn;
    logic [7:0]  d;
    logic [15:0] eo;
    bit          oe;
    bit          rdy;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit ce, input bit se, input bit sgn,
                     input logic [7:0] d, input logic [15:0] eo,
                     input bit oe, input bit rdy, input bit err);
    vec_t v;
    v.rst = rst; v.ce = ce; v.se = se; v.sgn = sgn; v.d = d;
    v.eo = eo; v.oe = oe; v.rdy = rdy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, i, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("data_out",   i, v.sgn ? 32'(dout_s) : 32'(dout_u), 32'(v.eo));
    chk("out_enable", i, v.sgn ? 32'(oe_s)   : 32'(oe_u),   32'(v.oe));
    chk("coef_ready", i, v.sgn ? 32'(rdy_s)  : 32'(rdy_u),  32'(v.rdy));
    chk("error",      i, v.sgn ? 32'(err_s)  : 32'(err_u),  32'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sat_exp [5];
`ifdef FIR_SATURATE_EN
    sat_exp = '{16'd65025, 16'd65535, 16'd65535, 16'd65535, 16'd65535};
`else
    sat_exp = '{16'd65025, 16'd64514, 16'd64003, 16'd63492, 16'd62981};
`endif
    reset = 1'b0; data_in = '0; coef_enable = 1'b0; sample_enable = 1'b0;

    // Basic filter: coefficients 4..8, six unit samples, then idle
    add(1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,4, 0,0,0,0);
    add(0,1,0,0,5, 0,0,0,0);
    add(0,1,0,0,6, 0,0,0,0);
    add(0,1,0,0,7, 0,0,0,0);
    add(0,1,0,0,8, 0,0,1,0);
    add(0,0,1,0,1, 4,1,1,0);
    add(0,0,1,0,1, 9,1,1,0);
    add(0,0,1,0,1, 15,1,1,0);
    add(0,0,1,0,1, 22,1,1,0);
    add(0,0,1,0,1, 30,1,1,0);
    add(0,0,1,0,1, 30,1,1,0);
    add(0,0,0,0,0, 30,0,1,0);
    // Reload 1,0,0,0,0 keeping history, then sample 3
    add(0,1,0,0,1, 30,0,0,0);
    add(0,1,0,0,0, 30,0,0,0);
    add(0,1,0,0,0, 30,0,0,0);
    add(0,1,0,0,0, 30,0,0,0);
    add(0,1,0,0,0, 30,0,1,0);
    add(0,0,1,0,3, 3,1,1,0);
    // Reset mid-load, then full reload with a gap between writes
    add(0,1,0,0,4, 3,0,0,0);
    add(0,1,0,0,5, 3,0,0,0);
    add(1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,9, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,1, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,1, 0,0,1,0);
    add(0,0,1,0,1, 9,1,1,0);
    // Conflicting enables in RUN: error, output frozen, later enables ignored
    add(0,1,1,0,7, 9,0,1,1);
    add(0,0,1,0,5, 9,0,1,1);
    add(0,1,0,0,5, 9,0,1,1);
    // Early sample during LOAD
    add(1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,1, 0,0,0,0);
    add(0,1,0,0,2, 0,0,0,0);
    add(0,1,0,0,3, 0,0,0,0);
    add(0,0,1,0,7, 0,0,0,1);
    add(0,0,1,0,7, 0,0,0,1);
    add(0,1,0,0,4, 0,0,0,1);
    add(0,1,0,0,5, 0,0,0,1);
    add(1,0,0,0,0, 0,0,0,0);
    // Saturation vs wrap: all-255 coefficients and samples
    for (int k = 0; k < 5; k++) add(0,1,0,0,8'hFF, 0,0,(k == 4),0);
    for (int k = 0; k < 5; k++) add(0,0,1,0,8'hFF, sat_exp[k],1,1,0);
    // Signed mode: coefficients -1, samples 2, 2
    add(1,0,0,1,0, 0,0,0,0);
    for (int k = 0; k < 5; k++) add(0,1,0,1,8'hFF, 0,0,(k == 4),0);
    add(0,0,1,1,2, 16'hFFFE,1,1,0);
    add(0,0,1,1,2, 16'hFFFC,1,1,0);
    add(0,0,0,1,0, 16'hFFFC,0,1,0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        @(negedge clk);
        coef_enable = 1'b0; sample_enable = 1'b0; data_in = '0; reset = 1'b0;
        #1 check_vec(i, vecs[i]);
        #1 reset = 1'b1;
      end else begin
        @(negedge clk);
        coef_enable = vecs[i].ce; sample_enable = vecs[i].se; data_in = vecs[i].d;
        @(posedge clk);
        #1 check_vec(i, vecs[i]);
      end
    end

    // Asynchronous reset in the middle of a clock phase, no edge involved
    @(negedge clk);
    coef_enable = 1'b0; sample_enable = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_dout_s", 0, 32'(dout_s), 32'd0);
    chk("async_rdy_s",  0, 32'(rdy_s),  32'd0);
    chk("async_dout_u", 0, 32'(dout_u), 32'd0);
    chk("async_rdy_u",  0, 32'(rdy_u),  32'd0);
    #1 reset = 1'b1;

    // After reset one short load must not report ready
    @(negedge clk);
    coef_enable = 1'b1; data_in = 8'd2;
    @(posedge clk);
    #1 chk("partial_rdy", 0, 32'(rdy_u), 32'd0);
    @(negedge clk);
    coef_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
